paint_writer: RTL and testbench

Framebuffer write engine that sits directly downstream of the PS/2 mouse controller. It consumes the binned cursor position and the left/right button levels, and turns them into single-port pixel writes. Holding the left button stamps a BRUSH×BRUSH square of `color` at the cursor. Each press of the right button sweeps the whole W×H framebuffer to the background colour. Its write port drives the VGA framebuffer RAM.

---
 rtl/paint_writer.sv | 166 ++++++++++++++++
 tb/tb_paint_writer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/paint_writer.sv
// Framebuffer write engine: stamps a BRUSH x BRUSH square while draw is held and
// sweeps the whole frame to BG on each rising edge of clr. All outputs registered.
module paint_writer #(
    parameter int                 W       = 640,
    parameter int                 H       = 480,
    parameter int                 BRUSH   = 2,
    parameter int                 COLOR_W = 3,
    parameter logic [COLOR_W-1:0] BG      = '0,
    parameter int                 ADDR_W  = $clog2(W*H)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [10:0]        x,
    input  logic [10:0]        y,
    input  logic               draw,
    input  logic               clr,
    input  logic [COLOR_W-1:0] color,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COLOR_W-1:0] wr_data,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_t;

    localparam logic [11:0]       W_L      = 12'(W);
    localparam logic [11:0]       H_L      = 12'(H);
    localparam logic [3:0]        B_LAST   = 4'(BRUSH - 1);
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(W*H - 1);

    state_t               state, state_nxt;
    logic                 clr_q, clr_pend, clr_pend_nxt;
    logic [10:0]          last_x, last_x_nxt, last_y, last_y_nxt;
    logic                 last_valid, last_valid_nxt;
    logic [10:0]          cx, cx_nxt, cy, cy_nxt;
    logic [COLOR_W-1:0]   col, col_nxt;
    logic [3:0]           dx, dx_nxt, dy, dy_nxt;
    logic [ADDR_W-1:0]    cnt, cnt_nxt;
    logic                 wr_en_nxt, busy_nxt;
    logic [ADDR_W-1:0]    wr_addr_nxt;
    logic [COLOR_W-1:0]   wr_data_nxt;

    logic [11:0]          px, py;
    logic [ADDR_W-1:0]    pix_addr;
    logic                 clr_req, in_frame, moved;

    // Clip test runs on the full 12-bit sum; the address only matters when in frame.
    assign px       = {1'b0, cx} + {8'b0, dx};
    assign py       = {1'b0, cy} + {8'b0, dy};
    assign pix_addr = ADDR_W'(py) * ADDR_W'(W) + ADDR_W'(px);
    assign clr_req  = clr & ~clr_q;
    assign in_frame = ({1'b0, x} < W_L) && ({1'b0, y} < H_L);
    assign moved    = !last_valid || (x != last_x) || (y != last_y);

    always_comb begin
        state_nxt      = state;
        clr_pend_nxt   = clr_pend;
        last_x_nxt     = last_x;
        last_y_nxt     = last_y;
        last_valid_nxt = last_valid;
        cx_nxt         = cx;
        cy_nxt         = cy;
        col_nxt        = col;
        dx_nxt         = dx;
        dy_nxt         = dy;
        cnt_nxt        = cnt;
        wr_en_nxt      = 1'b0;
        wr_addr_nxt    = wr_addr;
        wr_data_nxt    = wr_data;
        busy_nxt       = 1'b0;

        if (clr_req && state != CLEAR)
            clr_pend_nxt = 1'b1;

        case (state)
            IDLE: begin
                if (clr_pend) begin
                    clr_pend_nxt = 1'b0;
                    cnt_nxt      = '0;
                    state_nxt    = CLEAR;
                end else if (draw && in_frame && moved) begin
                    cx_nxt         = x;
                    cy_nxt         = y;
                    col_nxt        = color;
                    last_x_nxt     = x;
                    last_y_nxt     = y;
                    last_valid_nxt = 1'b1;
                    dx_nxt         = '0;
                    dy_nxt         = '0;
                    state_nxt      = PAINT;
                end else if (!draw) begin
                    last_valid_nxt = 1'b0;
                end
            end
            PAINT: begin
                busy_nxt    = 1'b1;
                wr_en_nxt   = (px < W_L) && (py < H_L);
                wr_addr_nxt = pix_addr;
                wr_data_nxt = col;
                if (dx == B_LAST) begin
                    dx_nxt = '0;
                    if (dy == B_LAST) begin
                        dy_nxt    = '0;
                        state_nxt = IDLE;
                    end else begin
                        dy_nxt = dy + 4'd1;
                    end
                end else begin
                    dx_nxt = dx + 4'd1;
                end
            end
            CLEAR: begin
                busy_nxt    = 1'b1;
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = cnt;
                wr_data_nxt = BG;
                if (cnt == CNT_LAST) begin
                    last_valid_nxt = 1'b0;
                    state_nxt      = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            clr_q      <= 1'b0;
            clr_pend   <= 1'b0;
            last_x     <= '0;
            last_y     <= '0;
            last_valid <= 1'b0;
            cx         <= '0;
            cy         <= '0;
            col        <= '0;
            dx         <= '0;
            dy         <= '0;
            cnt        <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            clr_q      <= clr;
            clr_pend   <= clr_pend_nxt;
            last_x     <= last_x_nxt;
            last_y     <= last_y_nxt;
            last_valid <= last_valid_nxt;
            cx         <= cx_nxt;
            cy         <= cy_nxt;
            col        <= col_nxt;
            dx         <= dx_nxt;
            dy         <= dy_nxt;
            cnt        <= cnt_nxt;
            wr_en      <= wr_en_nxt;
            wr_addr    <= wr_addr_nxt;
            wr_data    <= wr_data_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_paint_writer.sv
// Bench for paint_writer on a reduced 20x12 frame so full sweeps stay short;
// expected writes come from the brush/clear rules evaluated arithmetically.
module tb_paint_writer;

    localparam int              W  = 20;
    localparam int              H  = 12;
    localparam int              B  = 2;
    localparam int              CW = 3;
    localparam int              AW = $clog2(W*H);
    localparam logic [CW-1:0]   BG = 3'd6;

    logic          clk = 1'b0;
    logic          reset;
    logic [10:0]   x, y;
    logic          draw, clr;
    logic [CW-1:0] color;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wr_data;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a draw session remembers the last stamped position.
    bit sess = 0;
    int last_x = 0, last_y = 0;

    paint_writer #(.W(W), .H(H), .BRUSH(B), .COLOR_W(CW), .BG(BG)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .draw(draw), .clr(clr),
        .color(color), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check({tag, "_wr_en"}, wr_en, 0);
            check({tag, "_busy"}, busy, 0);
        end
    endtask

    // Called after the trigger edge; checks every brush cycle plus the idle cycle after.
    task automatic expect_stamp(input int sx, input int sy, input int c, input bit clr_mid);
        for (int k = 0; k < B*B; k++) begin
            int px, py;
            if (clr_mid && k == 1) clr = 1'b1;
            tick();
            px = sx + k % B;
            py = sy + k / B;
            check("stamp_busy", busy, 1);
            check("stamp_wr_en", wr_en, (px < W && py < H) ? 1 : 0);
            if (px < W && py < H) begin
                check("stamp_addr", wr_addr, py*W + px);
                check("stamp_data", wr_data, c);
            end
        end
        expect_idle("stamp_gap", 1);
    endtask

    // Checks a sweep whose start edge has passed; returns early if reset hits at abort_at.
    task automatic expect_sweep(input int mid_edge_at, input int abort_at);
        for (int i = 0; i < W*H; i++) begin
            if (i == mid_edge_at)     clr = 1'b0;
            if (i == mid_edge_at + 3) clr = 1'b1;
            if (i == mid_edge_at + 6) clr = 1'b0;
            if (i == abort_at) begin
                reset = 1'b1;
                tick();
                check("abort_wr_en", wr_en, 0);
                check("abort_busy", busy, 0);
                reset = 1'b0;
                return;
            end
            tick();
            check("sweep_wr_en", wr_en, 1);
            check("sweep_busy", busy, 1);
            check("sweep_addr", wr_addr, i);
            check("sweep_data", wr_data, BG);
        end
        expect_idle("sweep_end", 1);
    endtask

    task automatic step(input int nx, input int ny, input int c, input bit release_first);
        if (release_first) begin
            draw = 1'b0;
            expect_idle("release", 1);
            sess = 0;
        end
        x = 11'(nx);
        y = 11'(ny);
        color = CW'(c);
        draw = 1'b1;
        expect_idle("trigger", 1);
        if (nx < W && ny < H && (!sess || nx != last_x || ny != last_y)) begin
            expect_stamp(nx, ny, c, 1'b0);
            sess = 1;
            last_x = nx;
            last_y = ny;
        end else begin
            expect_idle("nostamp", 3);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x = 11'($urandom); y = 11'($urandom);
            draw = 1'($urandom); clr = 1'($urandom); color = CW'($urandom);
            tick();
            check("rst_wr_en", wr_en, 0);
            check("rst_addr", wr_addr, 0);
            check("rst_data", wr_data, 0);
            check("rst_busy", busy, 0);
        end
        reset = 1'b0; draw = 1'b0; clr = 1'b0; x = '0; y = '0; color = '0;
        tick();
        check("post_rst_wr_en", wr_en, 0);
        check("post_rst_addr", wr_addr, 0);
        check("post_rst_data", wr_data, 0);
        check("post_rst_busy", busy, 0);

        // Directed stamps: basic, stationary, moved, corner clip, out of range.
        step(3, 4, 5, 1'b0);
        expect_idle("stationary", 10);
        step(3, 4, 5, 1'b0);
        step(4, 4, 5, 1'b0);
        step(W-1, H-1, 2, 1'b0);
        step(W+5, 3, 1, 1'b0);
        step(3, H, 1, 1'b0);
        step(2047, 2047, 7, 1'b1);

        for (int n = 0; n < 40; n++) begin
            int nx, ny;
            nx = $urandom_range(0, W+3);
            ny = $urandom_range(0, H+2);
            if ($urandom_range(0, 3) == 0) begin
                nx = last_x;
                ny = last_y;
            end
            step(nx, ny, int'($urandom_range(0, 7)), $urandom_range(0, 3) == 0);
        end

        // Clear with draw held at a stamped position; second clr edge mid-sweep is dropped.
        step(5, 5, 3, 1'b1);
        clr = 1'b1;
        expect_idle("clr_req", 1);
        expect_idle("clr_take", 1);
        expect_sweep(10, -1);
        expect_stamp(5, 5, 3, 1'b0);
        expect_idle("one_sweep", 20);
        last_x = 5; last_y = 5;

        // Simultaneous clr edge and new draw position: stamp first, then sweep, then restamp.
        x = 11'd8; y = 11'd2; color = 3'd4; clr = 1'b1;
        expect_idle("simul_trig", 1);
        expect_stamp(8, 2, 4, 1'b0);
        clr = 1'b0;
        expect_sweep(-10, -1);
        expect_stamp(8, 2, 4, 1'b0);
        last_x = 8; last_y = 2;

        // clr edge during a stamp is deferred; reset mid-sweep aborts it for good.
        x = 11'd12; y = 11'd7; color = 3'd1;
        expect_idle("defer_trig", 1);
        expect_stamp(12, 7, 1, 1'b1);
        draw = 1'b0;
        expect_sweep(5, 100);
        expect_idle("after_abort", 30);
        sess = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
